// File: rtl/rf_agu_pkg.sv
// Shared types and constants for the register-file address generator.
// Holds the FSM state encoding, the latched instruction record and reset values.
package rf_agu_pkg;

  localparam int AGU_ADDR_W = 6;
  localparam int AGU_CNT_W  = 6;
  localparam int AGU_DLY_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_DLY,
    ST_ADDR,
    ST_MID_DLY,
    ST_RPT_DLY
  } agu_state_e;

  // One AGU instruction as latched on instr_start.
  typedef struct packed {
    logic [AGU_ADDR_W-1:0] start_addr;
    logic [AGU_ADDR_W-1:0] step;
    logic [AGU_CNT_W-1:0]  num_addr;
    logic [AGU_DLY_W-1:0]  init_delay;
    logic [AGU_DLY_W-1:0]  mid_delay;
    logic [AGU_CNT_W-1:0]  num_rpt;
    logic [AGU_ADDR_W-1:0] rpt_step;
    logic [AGU_DLY_W-1:0]  rpt_delay;
  } agu_cfg_t;

  localparam agu_state_e            AGU_STATE_RST = ST_IDLE;
  localparam agu_cfg_t              AGU_CFG_RST   = '0;
  localparam logic [AGU_ADDR_W-1:0] AGU_ADDR_RST  = '0;
  localparam logic [AGU_CNT_W-1:0]  AGU_CNT_RST   = '0;

  // True for the states that idle on the shared delay counter.
  function automatic logic is_delay_state(input agu_state_e s);
    return (s == ST_INIT_DLY) || (s == ST_MID_DLY) || (s == ST_RPT_DLY);
  endfunction

endpackage

// File: rtl/rf_agu_addr_gen_if.sv
// Sequencer <-> AGU bundle: instruction fields in, address stream out.
interface rf_agu_addr_gen_if #(
  parameter int ADDR_W = rf_agu_pkg::AGU_ADDR_W,
  parameter int CNT_W  = rf_agu_pkg::AGU_CNT_W,
  parameter int DLY_W  = rf_agu_pkg::AGU_DLY_W
);
  import rf_agu_pkg::*;

  logic              instr_start;
  logic [ADDR_W-1:0] cfg_start_addr;
  logic [ADDR_W-1:0] cfg_step;
  logic [CNT_W-1:0]  cfg_num_addr;
  logic [DLY_W-1:0]  cfg_init_delay;
  logic [DLY_W-1:0]  cfg_mid_delay;
  logic [CNT_W-1:0]  cfg_num_rpt;
  logic [ADDR_W-1:0] cfg_rpt_step;
  logic [DLY_W-1:0]  cfg_rpt_delay;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_en;
  logic              busy;
  logic              done;

  // Sequencer side.
  modport master (
    output instr_start, cfg_start_addr, cfg_step, cfg_num_addr, cfg_init_delay,
           cfg_mid_delay, cfg_num_rpt, cfg_rpt_step, cfg_rpt_delay,
    input  addr_out, addr_en, busy, done
  );

  // AGU side.
  modport slave (
    input  instr_start, cfg_start_addr, cfg_step, cfg_num_addr, cfg_init_delay,
           cfg_mid_delay, cfg_num_rpt, cfg_rpt_step, cfg_rpt_delay,
    output addr_out, addr_en, busy, done
  );

endinterface

// File: rtl/rf_agu_addr_gen_delay_cnt.sv
// Loadable down-counter with a zero flag; shared by all three delay phases.
module agu_delay_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load on entry to a delay phase, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rf_agu_addr_gen.sv
// Register-file address generator: one AGU instruction in, a timed address
// stream with per-cycle enable out. All outputs are registered; they are
// computed from the next state so the first address can appear the cycle
// after instr_start.
module rf_agu_addr_gen #(
  parameter int ADDR_W = rf_agu_pkg::AGU_ADDR_W,
  parameter int CNT_W  = rf_agu_pkg::AGU_CNT_W,
  parameter int DLY_W  = rf_agu_pkg::AGU_DLY_W
) (
  input logic              clk,
  input logic              rst_n,
  rf_agu_addr_gen_if.slave bus
);
  import rf_agu_pkg::*;

  agu_state_e        r_state, w_state_next;
  agu_cfg_t          r_cfg, w_cfg_in, w_cfg_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [CNT_W-1:0]  r_i, w_i_next;
  logic [CNT_W-1:0]  r_r, w_r_next;
  logic [ADDR_W-1:0] r_addr_out, w_addr_out_next;
  logic              r_addr_en, w_addr_en_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              w_cnt_load;
  logic [DLY_W-1:0]  w_cnt_val;
  logic              w_cnt_zero;

  // Pack the incoming instruction fields.
  always_comb begin
    w_cfg_in            = AGU_CFG_RST;
    w_cfg_in.start_addr = bus.cfg_start_addr;
    w_cfg_in.step       = bus.cfg_step;
    w_cfg_in.num_addr   = bus.cfg_num_addr;
    w_cfg_in.init_delay = bus.cfg_init_delay;
    w_cfg_in.mid_delay  = bus.cfg_mid_delay;
    w_cfg_in.num_rpt    = bus.cfg_num_rpt;
    w_cfg_in.rpt_step   = bus.cfg_rpt_step;
    w_cfg_in.rpt_delay  = bus.cfg_rpt_delay;
  end

  // Next state, address and counters. The latched start_addr field doubles
  // as the running repetition base. instr_start always restarts, even mid-stream.
  always_comb begin
    w_state_next = r_state;
    w_cfg_next   = r_cfg;
    w_addr_next  = r_addr;
    w_i_next     = r_i;
    w_r_next     = r_r;
    if (bus.instr_start) begin
      w_cfg_next   = w_cfg_in;
      w_addr_next  = w_cfg_in.start_addr;
      w_i_next     = AGU_CNT_RST;
      w_r_next     = AGU_CNT_RST;
      w_state_next = (w_cfg_in.init_delay != '0) ? ST_INIT_DLY : ST_ADDR;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_next = ST_IDLE;
        ST_INIT_DLY, ST_MID_DLY, ST_RPT_DLY: begin
          if (w_cnt_zero) w_state_next = ST_ADDR;
        end
        ST_ADDR: begin
          if (r_i < r_cfg.num_addr) begin
            w_addr_next  = r_addr + r_cfg.step;
            w_i_next     = r_i + 1'b1;
            w_state_next = (r_cfg.mid_delay != '0) ? ST_MID_DLY : ST_ADDR;
          end else if (r_r < r_cfg.num_rpt) begin
            w_cfg_next.start_addr = r_cfg.start_addr + r_cfg.rpt_step;
            w_addr_next  = r_cfg.start_addr + r_cfg.rpt_step;
            w_i_next     = AGU_CNT_RST;
            w_r_next     = r_r + 1'b1;
            w_state_next = (r_cfg.rpt_delay != '0) ? ST_RPT_DLY : ST_ADDR;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Reload the delay counter with (delay-1) whenever a delay phase is entered.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    if ((bus.instr_start || (w_state_next != r_state)) && is_delay_state(w_state_next)) begin
      w_cnt_load = 1'b1;
      unique case (w_state_next)
        ST_INIT_DLY: w_cnt_val = w_cfg_next.init_delay - 1'b1;
        ST_MID_DLY:  w_cnt_val = w_cfg_next.mid_delay - 1'b1;
        default:     w_cnt_val = w_cfg_next.rpt_delay - 1'b1;
      endcase
    end
  end

  agu_delay_cnt #(
    .W (DLY_W)
  ) u_delay_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  // Output values for the coming cycle; done marks the last address of the last repetition.
  always_comb begin
    w_addr_en_next  = (w_state_next == ST_ADDR);
    w_addr_out_next = w_addr_en_next ? w_addr_next : r_addr_out;
    w_busy_next     = (w_state_next != ST_IDLE);
    w_done_next     = w_addr_en_next && (w_i_next == w_cfg_next.num_addr) &&
                      (w_r_next == w_cfg_next.num_rpt);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= AGU_STATE_RST;
      r_cfg      <= AGU_CFG_RST;
      r_addr     <= AGU_ADDR_RST;
      r_i        <= AGU_CNT_RST;
      r_r        <= AGU_CNT_RST;
      r_addr_out <= AGU_ADDR_RST;
      r_addr_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cfg      <= w_cfg_next;
      r_addr     <= w_addr_next;
      r_i        <= w_i_next;
      r_r        <= w_r_next;
      r_addr_out <= w_addr_out_next;
      r_addr_en  <= w_addr_en_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign bus.addr_out = r_addr_out;
  assign bus.addr_en  = r_addr_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_rf_agu_addr_gen.sv
// Self-checking bench for rf_agu_addr_gen: directed cases plus random
// instructions, restarts and resets, compared cycle by cycle against an
// expected timeline built from the instruction fields.
module tb_rf_agu_addr_gen;
  import rf_agu_pkg::*;

  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_agu_addr_gen_if bus ();

  rf_agu_addr_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle behaviour of the current scenario.
  bit exp_en   [MAXC];
  int exp_addr [MAXC];
  bit exp_done [MAXC];
  bit exp_busy [MAXC];
  int model_hold = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic agu_cfg_t mk_cfg(input int sa, input int st, input int na, input int id,
                                      input int md, input int nr, input int rs, input int rd);
    agu_cfg_t c;
    c.start_addr = 6'(sa);
    c.step       = 6'(st);
    c.num_addr   = 6'(na);
    c.init_delay = 6'(id);
    c.mid_delay  = 6'(md);
    c.num_rpt    = 6'(nr);
    c.rpt_step   = 6'(rs);
    c.rpt_delay  = 6'(rd);
    return c;
  endfunction

  // Cycle of the final address when the instruction starts in cycle 0.
  function automatic int last_cycle(input agu_cfg_t c);
    return 1 + int'(c.init_delay) + int'(c.num_addr) * (int'(c.num_rpt) + 1) * (1 + int'(c.mid_delay))
           + int'(c.num_rpt) * (1 + int'(c.rpt_delay));
  endfunction

  task automatic clear_after(input int t0);
    for (int k = t0 + 1; k < MAXC; k++) begin
      exp_en[k] = 1'b0; exp_addr[k] = 0; exp_done[k] = 1'b0; exp_busy[k] = 1'b0;
    end
  endtask

  // Lay out the address stream of instruction c started in cycle t0.
  // Any older stream is cut off after t0.
  task automatic plan_stream(input int t0, input agu_cfg_t c, output int t_last);
    int t;
    clear_after(t0);
    t = t0 + 1 + int'(c.init_delay);
    t_last = t;
    for (int r = 0; r <= int'(c.num_rpt); r++) begin
      for (int i = 0; i <= int'(c.num_addr); i++) begin
        exp_en[t]   = 1'b1;
        exp_addr[t] = (int'(c.start_addr) + r * int'(c.rpt_step) + i * int'(c.step)) % 64;
        exp_done[t] = (r == int'(c.num_rpt)) && (i == int'(c.num_addr));
        t_last = t;
        t += (i < int'(c.num_addr)) ? 1 + int'(c.mid_delay) : 1 + int'(c.rpt_delay);
      end
    end
    for (int k = t0 + 1; k <= t_last; k++) exp_busy[k] = 1'b1;
  endtask

  task automatic drive_cfg(input agu_cfg_t c);
    bus.cfg_start_addr = c.start_addr;
    bus.cfg_step       = c.step;
    bus.cfg_num_addr   = c.num_addr;
    bus.cfg_init_delay = c.init_delay;
    bus.cfg_mid_delay  = c.mid_delay;
    bus.cfg_num_rpt    = c.num_rpt;
    bus.cfg_rpt_step   = c.rpt_step;
    bus.cfg_rpt_delay  = c.rpt_delay;
  endtask

  // Start c0 in cycle 0, optionally restart with c1 in cycle t1, optionally
  // reset in cycle rc (negative = unused). Entered just after a rising edge.
  task automatic run_scenario(input string name, input agu_cfg_t c0, input int t1,
                              input agu_cfg_t c1, input int rc);
    int end0, end1, len, pulses, errs0;
    errs0 = n_errors;
    clear_after(-1);
    plan_stream(0, c0, end0);
    len = end0;
    if (t1 >= 0) begin
      plan_stream(t1, c1, end1);
      len = (end1 > t1) ? end1 : t1;
    end
    if (rc >= 0) begin
      clear_after(rc);
      len = rc + 1;
    end
    len += 3;
    pulses = 0;
    for (int c = 0; c <= len; c++) begin
      bus.instr_start = (c == 0) || (c == t1);
      drive_cfg((c == t1) ? c1 : c0);
      rst_n = (c != rc);
      @(negedge clk);
      if (rc >= 0 && c == rc + 1) model_hold = 0;
      if (exp_en[c]) begin
        model_hold = exp_addr[c];
        pulses++;
      end
      check_val($sformatf("%s addr_en c%0d", name, c), 32'(bus.addr_en), 32'(exp_en[c]));
      check_val($sformatf("%s addr_out c%0d", name, c), 32'(bus.addr_out), 32'(model_hold));
      check_val($sformatf("%s done c%0d", name, c), 32'(bus.done), 32'(exp_done[c]));
      check_val($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'(exp_busy[c]));
      @(posedge clk);
      #1;
    end
    $display("txn %s: start=%0d step=%0d na=%0d nr=%0d restart@%0d reset@%0d pulses=%0d new_errors=%0d",
             name, c0.start_addr, c0.step, c0.num_addr, c0.num_rpt, t1, rc, pulses,
             n_errors - errs0);
  endtask

  initial begin
    agu_cfg_t c0, c1;
    int mode, t1, rc;

    bus.instr_start = 1'b1;
    drive_cfg(mk_cfg(5, 1, 2, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset addr_en", 32'(bus.addr_en), 32'd0);
    check_val("reset addr_out", 32'(bus.addr_out), 32'd0);
    check_val("reset done", 32'(bus.done), 32'd0);
    check_val("reset busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.instr_start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_hold = 0;

    run_scenario("linear", mk_cfg(4, 1, 3, 0, 0, 0, 0, 0), -1, mk_cfg(0, 0, 0, 0, 0, 0, 0, 0), -1);
    run_scenario("delays", mk_cfg(0, 2, 2, 3, 1, 0, 0, 0), -1, mk_cfg(0, 0, 0, 0, 0, 0, 0, 0), -1);
    run_scenario("reps", mk_cfg(10, 1, 1, 0, 0, 2, 8, 2), -1, mk_cfg(0, 0, 0, 0, 0, 0, 0, 0), -1);
    run_scenario("wrap", mk_cfg(1, 63, 3, 0, 0, 1, 60, 0), -1, mk_cfg(0, 0, 0, 0, 0, 0, 0, 0), -1);
    run_scenario("restart", mk_cfg(4, 1, 3, 0, 0, 0, 0, 0), 2, mk_cfg(20, 1, 3, 0, 0, 0, 0, 0), -1);
    run_scenario("reset_mid", mk_cfg(0, 2, 2, 3, 1, 0, 0, 0), -1, mk_cfg(0, 0, 0, 0, 0, 0, 0, 0), 3);

    for (int n = 0; n < 24; n++) begin
      c0 = mk_cfg($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 5),
                  $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 63), $urandom_range(0, 3));
      c1 = mk_cfg($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 5),
                  $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 63), $urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      t1 = -1;
      rc = -1;
      if (mode >= 6 && mode <= 8) t1 = $urandom_range(1, last_cycle(c0) + 2);
      if (mode == 9) rc = $urandom_range(1, last_cycle(c0) + 1);
      run_scenario($sformatf("rand%0d", n), c0, t1, c1, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
